// File: rtl/grpci2_axi_wr_frontend_pkg.sv
// Shared definitions for the GRPCI2 AXI write front end: response codes,
// FSM states and the command record handed to the AHB master controller.
package grpci2_axi_wr_frontend_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int CMD_W = 76;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } wr_state_e;

   typedef struct packed {
      logic [3:0]  id;
      logic [7:0]  len;
      logic [63:0] addr;
   } wcmd_t;

endpackage

// File: rtl/grpci2_axi_wr_frontend_if.sv
// AXI slave write channels (AW, W, B) of the write front end.
interface grpci2_axi_wr_frontend_if;

   logic [3:0]  s_awid;
   logic [63:0] s_awaddr;
   logic [7:0]  s_awlen;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wlast;
   logic        s_wvalid;
   logic        s_wready;
   logic [3:0]  s_bid;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;

   modport slave (
      input  s_awid, s_awaddr, s_awlen, s_awvalid,
      input  s_wdata, s_wstrb, s_wlast, s_wvalid,
      input  s_bready,
      output s_awready, s_wready, s_bid, s_bresp, s_bvalid
   );

   modport master (
      output s_awid, s_awaddr, s_awlen, s_awvalid,
      output s_wdata, s_wstrb, s_wlast, s_wvalid,
      output s_bready,
      input  s_awready, s_wready, s_bid, s_bresp, s_bvalid
   );

endinterface

// File: rtl/grpci2_cmd_fifo.sv
// First-word-fall-through command FIFO; the head entry is visible on dout_o
// whenever the FIFO is not empty.
module grpci2_cmd_fifo #(
   parameter int WIDTH = 76,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q;
   logic [AW-1:0]    rp_q;
   logic [CW-1:0]    cnt_q;
   logic             full_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (cnt_q == CW'(DEPTH));
   assign empty_o   = (cnt_q == CW'(0));
   assign push_ok_s = push_i & ~full_s;
   assign pop_ok_s  = pop_i & ~empty_o;
   assign dout_o    = mem_q[rp_q];
   assign count_o   = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= push_ok_s ? wp_q + AW'(1) : wp_q;
         rp_q  <= pop_ok_s ? rp_q + AW'(1) : rp_q;
         cnt_q <= cnt_q + CW'(push_ok_s) - CW'(pop_ok_s);
      end
   end

   // Storage carries no reset; only entries between the pointers are meaningful.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wp_q] <= din_i;
      end
   end

endmodule

// File: rtl/grpci2_axi_wr_frontend.sv
// AXI write front end: buffers whole bursts in a data ring, then queues a
// command for the AHB master controller and returns its completion on B.
module grpci2_axi_wr_frontend
   import grpci2_axi_wr_frontend_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int BUF_WORDS = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   grpci2_axi_wr_frontend_if.slave     axi,
   output logic [3:0]                  wcmd_id,
   output logic [7:0]                  wcmd_len,
   output logic [63:0]                 wcmd_addr,
   output logic                        wcmd_valid,
   input  logic                        wcmd_ready,
   input  logic [9:0]                  wdata_idx,
   output logic [31:0]                 wdata_dout,
   output logic [3:0]                  wdata_strb,
   input  logic [3:0]                  wresp_id,
   input  logic [7:0]                  wresp_len,
   input  logic [1:0]                  wresp_err,
   input  logic                        wresp_valid,
   output logic                        wresp_ready,
   output logic                        proto_err
);

   localparam int          CW        = $clog2(CMD_DEPTH) + 1;
   localparam logic [10:0] BUF_LIMIT = 11'(BUF_WORDS);

   wr_state_e   state_q, state_d;
   logic [3:0]  id_q, id_d;
   logic [63:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  beat_q, beat_d;
   logic [9:0]  wr_ptr_q, wr_ptr_d;
   logic [10:0] occ_q, occ_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [3:0]  bid_q, bid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        proto_err_q, proto_err_d;

   logic [35:0] ring_q [BUF_WORDS];

   logic          aw_fire_s, w_fire_s, last_beat_s, push_s, pop_s, rel_s, empty_s;
   logic [CW-1:0] cnt_s, cnt_d;
   logic [CMD_W-1:0] fifo_dout_s;
   wcmd_t         head_s;
   wcmd_t         new_cmd_s;

   assign aw_fire_s   = axi.s_awvalid & awready_q;
   assign w_fire_s    = axi.s_wvalid & wready_q;
   assign last_beat_s = (beat_q == len_q);
   assign push_s      = w_fire_s & last_beat_s;
   assign pop_s       = ~empty_s & wcmd_ready;
   assign rel_s       = wresp_valid & ~bvalid_q;
   assign new_cmd_s   = '{id: id_q, len: len_q, addr: addr_q};

   grpci2_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .din_i   (new_cmd_s),
      .pop_i   (pop_s),
      .dout_o  (fifo_dout_s),
      .empty_o (empty_s),
      .count_o (cnt_s)
   );

   assign head_s     = wcmd_t'(fifo_dout_s);
   assign wcmd_id    = head_s.id;
   assign wcmd_len   = head_s.len;
   assign wcmd_addr  = head_s.addr;
   assign wcmd_valid = ~empty_s;

   assign {wdata_strb, wdata_dout} = ring_q[wdata_idx];

   assign axi.s_awready = awready_q;
   assign axi.s_wready  = wready_q;
   assign axi.s_bvalid  = bvalid_q;
   assign axi.s_bid     = bid_q;
   assign axi.s_bresp   = bresp_q;
   assign wresp_ready   = ~bvalid_q;
   assign proto_err     = proto_err_q;

   // Burst sequencing, occupancy bookkeeping and next values of the registered handshakes.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (aw_fire_s) begin
               state_d = ST_DATA;
               id_d    = axi.s_awid;
               addr_d  = axi.s_awaddr;
               len_d   = axi.s_awlen;
               beat_d  = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (push_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DATA;
            end
            beat_d = w_fire_s ? beat_q + 8'd1 : beat_q;
         end
         default: state_d = ST_IDLE;
      endcase

      wr_ptr_d    = w_fire_s ? wr_ptr_q + 10'd1 : wr_ptr_q;
      proto_err_d = proto_err_q | (w_fire_s & (axi.s_wlast ^ last_beat_s));
      occ_d       = occ_q + 11'(w_fire_s)
                    - (rel_s ? ({3'b000, wresp_len} + 11'd1) : 11'd0);
      cnt_d       = cnt_s + CW'(push_s) - CW'(pop_s);

      bvalid_d = bvalid_q;
      bid_d    = bid_q;
      bresp_d  = bresp_q;
      if (rel_s) begin
         bvalid_d = 1'b1;
         bid_d    = wresp_id;
         bresp_d  = wresp_err;
      end else if (bvalid_q && axi.s_bready) begin
         bvalid_d = 1'b0;
      end else begin
         bvalid_d = bvalid_q;
      end

      // Readies are registered from next state so they read 0 throughout reset.
      awready_d = (state_d == ST_IDLE) && (cnt_d != CW'(CMD_DEPTH));
      wready_d  = (state_d == ST_DATA) && (occ_d < BUF_LIMIT);
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         id_q        <= 4'd0;
         addr_q      <= 64'd0;
         len_q       <= 8'd0;
         beat_q      <= 8'd0;
         wr_ptr_q    <= 10'd0;
         occ_q       <= 11'd0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bid_q       <= 4'd0;
         bresp_q     <= RESP_OKAY;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         wr_ptr_q    <= wr_ptr_d;
         occ_q       <= occ_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bid_q       <= bid_d;
         bresp_q     <= bresp_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Data ring write port.
   always_ff @(posedge clk) begin
      if (w_fire_s) begin
         ring_q[wr_ptr_q] <= {axi.s_wstrb, axi.s_wdata};
      end
   end

endmodule

// File: tb/tb_grpci2_axi_wr_frontend.sv
// Directed plus randomized bench for grpci2_axi_wr_frontend, checked against
// a queue/array model of the ring, occupancy and command stream.
module tb_grpci2_axi_wr_frontend;

   logic        clk;
   logic        rst;
   logic [3:0]  wcmd_id;
   logic [7:0]  wcmd_len;
   logic [63:0] wcmd_addr;
   logic        wcmd_valid;
   logic        wcmd_ready;
   logic [9:0]  wdata_idx;
   logic [31:0] wdata_dout;
   logic [3:0]  wdata_strb;
   logic [3:0]  wresp_id;
   logic [7:0]  wresp_len;
   logic [1:0]  wresp_err;
   logic        wresp_valid;
   logic        wresp_ready;
   logic        proto_err;

   grpci2_axi_wr_frontend_if axi ();

   grpci2_axi_wr_frontend #(.CMD_DEPTH(4), .BUF_WORDS(1024)) dut (
      .clk         (clk),
      .rst         (rst),
      .axi         (axi),
      .wcmd_id     (wcmd_id),
      .wcmd_len    (wcmd_len),
      .wcmd_addr   (wcmd_addr),
      .wcmd_valid  (wcmd_valid),
      .wcmd_ready  (wcmd_ready),
      .wdata_idx   (wdata_idx),
      .wdata_dout  (wdata_dout),
      .wdata_strb  (wdata_strb),
      .wresp_id    (wresp_id),
      .wresp_len   (wresp_len),
      .wresp_err   (wresp_err),
      .wresp_valid (wresp_valid),
      .wresp_ready (wresp_ready),
      .proto_err   (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [35:0] mref [1024];
   int          ptr = 0;
   int          occ = 0;
   logic        exp_proto = 1'b0;
   logic [75:0] cmdq [$];

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      axi.s_awid = id; axi.s_awaddr = addr; axi.s_awlen = len; axi.s_awvalid = 1'b1;
      while (axi.s_awready !== 1'b1 && n < 3000) begin step(); n++; end
      chk("aw_handshake", axi.s_awready, 1'b1);
      step();
      axi.s_awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic lst, input logic is_last);
      int n = 0;
      axi.s_wdata = d; axi.s_wstrb = s; axi.s_wlast = lst; axi.s_wvalid = 1'b1;
      while (axi.s_wready !== 1'b1 && n < 3000) begin step(); n++; end
      chk("w_handshake", axi.s_wready, 1'b1);
      step();
      axi.s_wvalid = 1'b0;
      mref[ptr] = {s, d};
      ptr = (ptr + 1) % 1024;
      occ++;
      if (lst != is_last) exp_proto = 1'b1;
   endtask

   task automatic burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len, input int bad_beat);
      logic [31:0] d;
      logic [3:0]  s;
      aw_send(id, addr, len);
      for (int k = 0; k <= int'(len); k++) begin
         d = $urandom;
         s = 4'($urandom);
         w_send(d, s, (k == int'(len)) != (k == bad_beat), k == int'(len));
      end
      cmdq.push_back({id, len, addr});
      chk("proto_err", proto_err, exp_proto);
   endtask

   task automatic ring_chk(input int base, input int n);
      int i;
      for (int k = 0; k < n; k++) begin
         i = (base + k) % 1024;
         wdata_idx = 10'(i);
         #1;
         chk("ring_read", {wdata_strb, wdata_dout}, mref[i]);
      end
      step();
   endtask

   task automatic pop_chk();
      logic [75:0] e;
      e = cmdq[0];
      chk("wcmd_head", {wcmd_valid, wcmd_id, wcmd_len, wcmd_addr}, {1'b1, e});
      wcmd_ready = 1'b1;
      step();
      wcmd_ready = 1'b0;
      void'(cmdq.pop_front());
      chk("wcmd_valid_after_pop", wcmd_valid, cmdq.size() != 0);
   endtask

   task automatic resp(input logic [3:0] id, input logic [7:0] len, input logic [1:0] err, input int hold);
      chk("wresp_ready_idle", wresp_ready, 1'b1);
      wresp_id = id; wresp_len = len; wresp_err = err; wresp_valid = 1'b1;
      step();
      wresp_valid = 1'b0;
      occ -= int'(len) + 1;
      chk("b_channel", {axi.s_bvalid, axi.s_bid, axi.s_bresp}, {1'b1, id, err});
      for (int h = 0; h < hold; h++) begin
         step();
         chk("b_hold", {axi.s_bvalid, wresp_ready}, 2'b10);
      end
      axi.s_bready = 1'b1;
      step();
      axi.s_bready = 1'b0;
      chk("b_done", {axi.s_bvalid, wresp_ready}, 2'b01);
   endtask

   task automatic reset_outputs_chk(input string tag);
      chk(tag, {axi.s_awready, axi.s_wready, axi.s_bvalid, axi.s_bid, axi.s_bresp,
                wcmd_valid, proto_err, wresp_ready}, {3'b000, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      logic [3:0]  rid;
      logic [7:0]  rlen;
      logic [1:0]  rerr;
      logic [31:0] rd;
      int          base;
      rst = 1'b1;
      axi.s_awid = 4'd0; axi.s_awaddr = 64'd0; axi.s_awlen = 8'd0; axi.s_awvalid = 1'b0;
      axi.s_wdata = 32'd0; axi.s_wstrb = 4'd0; axi.s_wlast = 1'b0; axi.s_wvalid = 1'b0;
      axi.s_bready = 1'b0;
      wcmd_ready = 1'b0; wdata_idx = 10'd0;
      wresp_id = 4'd0; wresp_len = 8'd0; wresp_err = 2'd0; wresp_valid = 1'b0;

      // Reset state
      repeat (3) step();
      reset_outputs_chk("reset_state");
      rst = 1'b0;
      step();
      chk("post_reset_ready", {axi.s_awready, axi.s_wready, wresp_ready}, 3'b101);

      // Single-beat write and its completion with a stalled B channel
      aw_send(4'd3, 64'h1000, 8'd0);
      w_send(32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
      cmdq.push_back({4'd3, 8'd0, 64'h1000});
      chk("single_wcmd", {wcmd_valid, wcmd_id, wcmd_len, wcmd_addr}, {1'b1, 4'd3, 8'd0, 64'h1000});
      wdata_idx = 10'd0;
      #1;
      chk("single_ring", {wdata_strb, wdata_dout}, {4'hF, 32'hDEADBEEF});
      step();
      pop_chk();
      resp(4'd3, 8'd0, 2'b00, 5);

      // Randomized bursts
      for (int b = 0; b < 8; b++) begin
         rid  = 4'($urandom);
         rlen = 8'($urandom_range(0, 15));
         rerr = 2'($urandom);
         base = ptr;
         burst(rid, {$urandom, $urandom}, rlen, -1);
         ring_chk(base, int'(rlen) + 1);
         pop_chk();
         resp(rid, rlen, rerr, int'($urandom_range(0, 2)));
      end

      // Command FIFO full blocks AW; one pop reopens it on the next cycle
      for (int i = 0; i < 4; i++) burst(4'(i + 8), 64'h2000 + 64'(i * 4), 8'd0, -1);
      chk("aw_fifo_full", axi.s_awready, cmdq.size() < 4);
      axi.s_awid = 4'd12; axi.s_awaddr = 64'h2010; axi.s_awlen = 8'd0; axi.s_awvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("aw_blocked", axi.s_awready, 1'b0);
      end
      pop_chk();
      chk("aw_reopen", axi.s_awready, 1'b1);
      step();
      axi.s_awvalid = 1'b0;
      chk("aw_taken", axi.s_awready, 1'b0);
      w_send(32'hCAFE0005, 4'h3, 1'b1, 1'b1);
      cmdq.push_back({4'd12, 8'd0, 64'h2010});
      for (int i = 0; i < 4; i++) pop_chk();
      for (int i = 0; i < 5; i++) resp(4'(i + 8), 8'd0, 2'b00, 0);

      // Early WLAST: flagged, all beats still stored, command length kept
      chk("proto_clear", proto_err, exp_proto);
      base = ptr;
      burst(4'd5, 64'h3000, 8'd3, 1);
      chk("proto_set", proto_err, 1'b1);
      ring_chk(base, 4);
      pop_chk();
      resp(4'd5, 8'd3, 2'b10, 0);

      // Ring full at 1024 entries stalls W until a completion frees space
      for (int i = 0; i < 4; i++) begin
         burst(4'(i), 64'h10000 * 64'(i + 1), 8'd255, -1);
         pop_chk();
      end
      aw_send(4'd4, 64'h50000, 8'd255);
      axi.s_wdata = 32'h0BAD0BAD; axi.s_wstrb = 4'hF; axi.s_wlast = 1'b0; axi.s_wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("w_stall_full", axi.s_wready, occ < 1024);
      end
      axi.s_wvalid = 1'b0;
      resp(4'd0, 8'd255, 2'b00, 0);
      chk("w_resume", axi.s_wready, occ < 1024);
      base = ptr;
      for (int k = 0; k < 256; k++) begin
         rd = $urandom;
         w_send(rd, 4'($urandom), k == 255, k == 255);
      end
      cmdq.push_back({4'd4, 8'd255, 64'h50000});
      chk("ptr_wrap_idle_wready", axi.s_wready, 1'b0);
      ring_chk(base, 256);
      ring_chk(1020, 8);
      pop_chk();
      for (int i = 1; i < 5; i++) resp(4'(i), 8'd255, 2'b01, 0);

      // Reset mid-burst discards the burst and the queued command
      burst(4'd9, 64'h6000, 8'd0, -1);
      aw_send(4'd10, 64'h7000, 8'd7);
      w_send($urandom, 4'hF, 1'b0, 1'b0);
      w_send($urandom, 4'hF, 1'b0, 1'b0);
      chk("pre_reset_queued", wcmd_valid, cmdq.size() != 0);
      rst = 1'b1;
      #1;
      reset_outputs_chk("midburst_reset_async");
      step();
      reset_outputs_chk("midburst_reset_next");
      step();
      rst = 1'b0;
      cmdq.delete();
      ptr = 0; occ = 0; exp_proto = 1'b0;
      step();
      chk("after_reset_aw", axi.s_awready, 1'b1);
      burst(4'd6, 64'h8000, 8'd0, -1);
      ring_chk(0, 1);
      pop_chk();
      resp(4'd6, 8'd0, 2'b00, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
